// File: rtl/ctrl_regfile_pkg.sv
`default_nettype none
// ctrl_regfile_pkg: shared response codes, decode result type, sizing helpers
// and the default 32-bit AXI-Lite request/response structs for ctrl_regfile.
package ctrl_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    DEC_GENERAL = 2'd0,
    DEC_COUNTER = 2'd1,
    DEC_INVALID = 2'd2
  } decode_e;

  // Number of bus words the 64-bit cycle counter occupies.
  function automatic int unsigned cnt_words(input int unsigned data_width);
    return 64 / data_width;
  endfunction

  // Width of the word index once the byte offset is stripped from the address.
  function automatic int unsigned idx_width(input int unsigned addr_width,
                                            input int unsigned data_width);
    return addr_width - $clog2(data_width / 8);
  endfunction

  typedef struct packed {
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        r_ready;
  } axi_lite_req_32_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } axi_lite_resp_32_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_regfile_counter.sv
`default_nettype none
// ctrl_regfile_counter: free-running 64-bit cycle counter with a high-word
// snapshot captured whenever the low word is read.
module ctrl_regfile_counter #(
  parameter logic [63:0] RstVal = '0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        count_en_i,
  input  logic        lo_rd_i,
  output logic [63:0] cnt_o,
  output logic [31:0] hi_snap_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o     <= RstVal;
      hi_snap_o <= '0;
    end else begin
      if (count_en_i) cnt_o <= cnt_o + 64'd1;
      if (lo_rd_i)    hi_snap_o <= cnt_o[63:32];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_regfile.sv
`default_nettype none
// ctrl_regfile: AXI-Lite control/status register file with RO/RW registers,
// hardware load ports, write pulses, sticky exit flag and a 64-bit cycle counter.
module ctrl_regfile
  import ctrl_regfile_pkg::*;
#(
  parameter int unsigned                        DataWidth    = 32,
  parameter int unsigned                        AddrWidth    = 32,
  parameter int unsigned                        NumRegs      = 3,
  parameter logic [NumRegs-1:0]                 ReadOnlyMask = '0,
  parameter logic [NumRegs-1:0][DataWidth-1:0]  RegRstVal    = '0,
  parameter logic [63:0]                        CntRstVal    = '0,
  parameter type axi_lite_req_t  = axi_lite_req_32_t,
  parameter type axi_lite_resp_t = axi_lite_resp_32_t
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  axi_lite_req_t                       axi_lite_slave_req_i,
  output axi_lite_resp_t                      axi_lite_slave_resp_o,
  input  logic [NumRegs-1:0][DataWidth-1:0]   reg_d_i,
  input  logic [NumRegs-1:0]                  reg_load_i,
  input  logic                                count_en_i,
  output logic [NumRegs-1:0][DataWidth-1:0]   reg_q_o,
  output logic [NumRegs-1:0]                  reg_wr_pulse_o,
  output logic [DataWidth-1:0]                exit_o
);

  localparam int unsigned     StrbWidth = DataWidth / 8;
  localparam int unsigned     OffW      = $clog2(StrbWidth);
  localparam int unsigned     IdxW      = idx_width(AddrWidth, DataWidth);
  localparam int unsigned     CntWords  = cnt_words(DataWidth);
  localparam logic [IdxW-1:0] CntBase   = IdxW'(NumRegs);
  localparam logic [IdxW-1:0] CntEnd    = IdxW'(NumRegs + CntWords);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} chan_state_e;

  chan_state_e          wr_state, rd_state;
  logic [IdxW-1:0]      aw_idx, ar_idx;
  decode_e              aw_dec, ar_dec;
  logic                 aw_hs, ar_hs, ar_ready, exit_valid, lo_rd;
  logic [1:0]           b_resp, r_resp;
  logic [DataWidth-1:0] r_data, rd_word, cnt_rd_word;
  logic [NumRegs-1:0]   wr_hit, wr_en;
  logic [63:0]          cnt;
  logic [31:0]          hi_snap;
  logic                 unused_addr_lsbs;

  function automatic decode_e decode(input logic [IdxW-1:0] idx);
    if (idx < CntBase) return DEC_GENERAL;
    if (idx < CntEnd)  return DEC_COUNTER;
    return DEC_INVALID;
  endfunction

  assign aw_idx = axi_lite_slave_req_i.aw_addr[AddrWidth-1:OffW];
  assign ar_idx = axi_lite_slave_req_i.ar_addr[AddrWidth-1:OffW];
  assign aw_dec = decode(aw_idx);
  assign ar_dec = decode(ar_idx);
  assign unused_addr_lsbs = ^{axi_lite_slave_req_i.aw_addr[OffW-1:0],
                              axi_lite_slave_req_i.ar_addr[OffW-1:0]};

  assign aw_hs = axi_lite_slave_req_i.aw_valid & axi_lite_slave_req_i.w_valid &
                 (wr_state == IDLE);
  assign ar_hs = axi_lite_slave_req_i.ar_valid & ar_ready;

  for (genvar i = 0; i < NumRegs; i++) begin : g_wr_sel
    assign wr_hit[i] = aw_hs && (aw_dec == DEC_GENERAL) && (aw_idx == IdxW'(i));
    assign wr_en[i]  = wr_hit[i] & ~ReadOnlyMask[i];
  end

  ctrl_regfile_counter #(
    .RstVal (CntRstVal)
  ) u_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .count_en_i (count_en_i),
    .lo_rd_i    (lo_rd),
    .cnt_o      (cnt),
    .hi_snap_o  (hi_snap)
  );

  // A 32-bit bus splits the counter; the high word comes from the snapshot.
  if (DataWidth == 32) begin : g_cnt32
    logic unused_cnt_hi;
    assign unused_cnt_hi = ^cnt[63:32];
    assign cnt_rd_word   = (ar_idx == CntBase) ? cnt[31:0] : hi_snap;
    assign lo_rd         = ar_hs && (ar_idx == CntBase);
  end else begin : g_cnt64
    logic unused_snap;
    assign unused_snap = ^hi_snap;
    assign cnt_rd_word = cnt[DataWidth-1:0];
    assign lo_rd       = 1'b0;
  end

  always_comb begin
    rd_word = '0;
    if (ar_dec == DEC_GENERAL) begin
      for (int i = 0; i < NumRegs; i++) begin
        if (ar_idx == IdxW'(i)) rd_word = reg_q_o[i];
      end
    end else if (ar_dec == DEC_COUNTER) begin
      rd_word = cnt_rd_word;
    end
  end

  // Hardware load takes priority over a colliding bus write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state       <= IDLE;
      b_resp         <= RESP_OKAY;
      reg_q_o        <= RegRstVal;
      reg_wr_pulse_o <= '0;
      exit_valid     <= 1'b0;
    end else begin
      reg_wr_pulse_o <= wr_en;
      case (wr_state)
        IDLE: if (aw_hs) begin
          wr_state <= RESP;
          b_resp   <= (aw_dec == DEC_INVALID) ? RESP_SLVERR : RESP_OKAY;
        end
        RESP: if (axi_lite_slave_req_i.b_ready) wr_state <= IDLE;
      endcase
      if (wr_hit[0]) exit_valid <= 1'b1;
      for (int i = 0; i < NumRegs; i++) begin
        if (reg_load_i[i]) begin
          reg_q_o[i] <= reg_d_i[i];
        end else if (wr_en[i]) begin
          for (int b = 0; b < StrbWidth; b++) begin
            if (axi_lite_slave_req_i.w_strb[b])
              reg_q_o[i][8*b +: 8] <= axi_lite_slave_req_i.w_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state <= IDLE;
      ar_ready <= 1'b0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        IDLE: if (ar_hs) begin
          rd_state <= RESP;
          ar_ready <= 1'b0;
          r_data   <= rd_word;
          r_resp   <= (ar_dec == DEC_INVALID) ? RESP_SLVERR : RESP_OKAY;
        end else begin
          ar_ready <= 1'b1;
        end
        RESP: if (axi_lite_slave_req_i.r_ready) begin
          rd_state <= IDLE;
          ar_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    axi_lite_slave_resp_o          = '0;
    axi_lite_slave_resp_o.aw_ready = aw_hs;
    axi_lite_slave_resp_o.w_ready  = aw_hs;
    axi_lite_slave_resp_o.b_valid  = (wr_state == RESP);
    axi_lite_slave_resp_o.b_resp   = b_resp;
    axi_lite_slave_resp_o.ar_ready = ar_ready;
    axi_lite_slave_resp_o.r_valid  = (rd_state == RESP);
    axi_lite_slave_resp_o.r_data   = r_data;
    axi_lite_slave_resp_o.r_resp   = r_resp;
  end

  assign exit_o = {reg_q_o[0][DataWidth-2:0], exit_valid};

endmodule
`default_nettype wire

// File: tb/tb_ctrl_regfile.sv
`default_nettype none
// tb_ctrl_regfile: directed bus transactions; expected B/R responses are queued
// and checked by a separate monitor. A second instance starts its counter preloaded.
module tb_ctrl_regfile;
  import ctrl_regfile_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 3;
  localparam logic [NR-1:0] RO_MASK = 3'b010;
  localparam logic [NR-1:0][DW-1:0] RST_VAL = {32'h0000_00A5, 32'hDEAD_BEEF, 32'h0000_0010};
  localparam logic [31:0] A_REG0 = 32'h00, A_REG1 = 32'h04, A_REG2 = 32'h08;
  localparam logic [31:0] A_CNT_LO = 32'h0C, A_CNT_HI = 32'h10, A_BAD = 32'h14;

  typedef struct {
    string       name;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, count_en = 1'b0, sel = 1'b0;
  axi_lite_req_32_t  req;
  axi_lite_resp_32_t resp_a, resp_b, resp;
  logic [NR-1:0][DW-1:0] reg_d, reg_q_a, reg_q_b;
  logic [NR-1:0] reg_load, pulse_a, pulse_b;
  logic [DW-1:0] exit_a, exit_b;
  exp_t bq[$];
  exp_t rq[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign resp = sel ? resp_b : resp_a;

  ctrl_regfile #(
    .DataWidth(DW), .AddrWidth(32), .NumRegs(NR), .ReadOnlyMask(RO_MASK),
    .RegRstVal(RST_VAL), .CntRstVal(64'h0),
    .axi_lite_req_t(axi_lite_req_32_t), .axi_lite_resp_t(axi_lite_resp_32_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_lite_slave_req_i(req), .axi_lite_slave_resp_o(resp_a),
    .reg_d_i(reg_d), .reg_load_i(reg_load), .count_en_i(count_en),
    .reg_q_o(reg_q_a), .reg_wr_pulse_o(pulse_a), .exit_o(exit_a)
  );

  ctrl_regfile #(
    .DataWidth(DW), .AddrWidth(32), .NumRegs(NR), .ReadOnlyMask(RO_MASK),
    .RegRstVal(RST_VAL), .CntRstVal(64'h0000_0000_FFFF_FFFF),
    .axi_lite_req_t(axi_lite_req_32_t), .axi_lite_resp_t(axi_lite_resp_32_t)
  ) dut_pre (
    .clk_i(clk), .rst_ni(rst_n), .axi_lite_slave_req_i(req), .axi_lite_slave_resp_o(resp_b),
    .reg_d_i(reg_d), .reg_load_i(reg_load), .count_en_i(count_en),
    .reg_q_o(reg_q_b), .reg_wr_pulse_o(pulse_b), .exit_o(exit_b)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Response monitor: every completed B/R handshake is matched against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp.b_valid && req.b_ready) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_b: got bresp %b required no response", resp.b_resp);
      end else begin
        e = bq.pop_front();
        if (resp.b_resp !== e.resp) begin
          errors++;
          $display("FAIL %s: got bresp %b required %b", e.name, resp.b_resp, e.resp);
        end
      end
    end
    if (rst_n && resp.r_valid && req.r_ready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_r: got rdata %h required no response", resp.r_data);
      end else begin
        e = rq.pop_front();
        if (resp.r_resp !== e.resp || resp.r_data !== e.data) begin
          errors++;
          $display("FAIL %s: got resp %b data %h required resp %b data %h",
                   e.name, resp.r_resp, resp.r_data, e.resp, e.data);
        end
      end
    end
  end

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required handshake", name);
  endtask

  // Returns #1 after the AW/W handshake edge; optionally loads reg 2 in that same cycle.
  task automatic axi_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input logic load2, input logic [31:0] load_data);
    int n;
    bq.push_back('{name, exp_resp, 32'h0});
    req.aw_addr = addr; req.w_data = data; req.w_strb = strb;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    if (load2) begin reg_d[2] = load_data; reg_load = 3'b100; end
    n = 0;
    @(negedge clk);
    while (!resp.aw_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin timeout_fail({name, "_aw"}); void'(bq.pop_back()); end
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0; reg_load = '0;
  endtask

  task automatic finish_b(input int delay);
    int n;
    for (int k = 0; k < delay; k++) begin
      @(posedge clk); #1;
      check("bvalid_held", resp.b_valid, 1);
    end
    req.b_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp.b_valid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout_fail("b_wait");
    @(posedge clk); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic axi_read(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    rq.push_back('{name, exp_resp, exp_data});
    req.ar_addr = addr; req.ar_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp.ar_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin timeout_fail({name, "_ar"}); void'(rq.pop_back()); end
    @(posedge clk); #1;
    req.ar_valid = 1'b0; req.r_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp.r_valid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout_fail({name, "_r"});
    @(posedge clk); #1;
    req.r_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req = '0; reg_d = '0; reg_load = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_reg_q", reg_q_a, RST_VAL);
    check("rst_reg_q_pre", reg_q_b, RST_VAL);
    check("rst_exit", exit_a, 32'h0000_0020);
    check("rst_exit_pre", exit_b, 32'h0000_0020);
    check("rst_pulse", {pulse_b, pulse_a}, 0);
    check("rst_valids", {resp.b_valid, resp.r_valid, resp.ar_ready}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    axi_read("rd_cnt_lo_rst", A_CNT_LO, 32'h0, RESP_OKAY);
    axi_read("rd_cnt_hi_rst", A_CNT_HI, 32'h0, RESP_OKAY);
    axi_read("rd_reg1_rst", A_REG1, 32'hDEAD_BEEF, RESP_OKAY);

    axi_write("wr_reg0", A_REG0, 32'h5, 4'hF, RESP_OKAY, 1'b0, 32'h0);
    check("wr_reg0_q", reg_q_a[0], 32'h5);
    check("wr_reg0_pulse", pulse_a, 3'b001);
    check("wr_reg0_exit", exit_a, 32'hB);
    check("wr_reg0_bvalid", resp.b_valid, 1);
    @(posedge clk); #1;
    check("wr_reg0_pulse_drop", pulse_a, 3'b000);
    finish_b(2);
    check("wr_reg0_bvalid_drop", resp.b_valid, 0);

    axi_write("wr_ro_reg1", A_REG1, 32'hFFFF_FFFF, 4'hF, RESP_OKAY, 1'b0, 32'h0);
    check("wr_ro_reg1_q", reg_q_a[1], 32'hDEAD_BEEF);
    check("wr_ro_reg1_pulse", pulse_a, 3'b000);
    finish_b(0);

    axi_write("wr_reg2_strb", A_REG2, 32'hAABB_CCDD, 4'b0010, RESP_OKAY, 1'b0, 32'h0);
    check("wr_reg2_strb_q", reg_q_a[2], 32'h0000_CCA5);
    check("wr_reg2_strb_pulse", pulse_a, 3'b100);
    finish_b(0);

    axi_read("rd_invalid", A_BAD, 32'h0, RESP_SLVERR);
    axi_write("wr_invalid", A_BAD, 32'h0000_0123, 4'hF, RESP_SLVERR, 1'b0, 32'h0);
    check("wr_invalid_q", reg_q_a, {32'h0000_CCA5, 32'hDEAD_BEEF, 32'h0000_0005});
    check("wr_invalid_pulse", pulse_a, 3'b000);
    finish_b(0);

    axi_write("wr_cnt_lo", A_CNT_LO, 32'h1234_5678, 4'hF, RESP_OKAY, 1'b0, 32'h0);
    check("wr_cnt_lo_pulse", pulse_a, 3'b000);
    finish_b(0);
    axi_read("rd_cnt_lo_after_wr", A_CNT_LO, 32'h0, RESP_OKAY);

    axi_write("wr_collide", A_REG2, 32'h9, 4'hF, RESP_OKAY, 1'b1, 32'h1234);
    check("collide_q", reg_q_a[2], 32'h1234);
    check("collide_pulse", pulse_a, 3'b100);
    finish_b(0);

    reg_d[1] = 32'h77; reg_load = 3'b010;
    @(posedge clk); #1;
    reg_load = '0;
    check("hw_load_ro_q", reg_q_a[1], 32'h77);

    sel = 1'b1;
    axi_read("pre_cnt_lo", A_CNT_LO, 32'hFFFF_FFFF, RESP_OKAY);
    axi_read("pre_cnt_hi", A_CNT_HI, 32'h0, RESP_OKAY);
    count_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    count_en = 1'b0;
    axi_read("pre_cnt_hi_snap", A_CNT_HI, 32'h0, RESP_OKAY);
    axi_read("pre_cnt_lo_wrapped", A_CNT_LO, 32'h9, RESP_OKAY);
    axi_read("pre_cnt_hi_carry", A_CNT_HI, 32'h1, RESP_OKAY);
    sel = 1'b0;
    axi_read("cnt_lo_ten", A_CNT_LO, 32'hA, RESP_OKAY);

    // Read and write of reg 0 in the same cycle: read must see the old value.
    rq.push_back('{"same_cycle_rd", RESP_OKAY, 32'h5});
    bq.push_back('{"same_cycle_wr", RESP_OKAY, 32'h0});
    req.aw_addr = A_REG0; req.w_data = 32'h66; req.w_strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    req.ar_addr = A_REG0; req.ar_valid = 1'b1;
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    check("same_cycle_q", reg_q_a[0], 32'h66);
    check("same_cycle_exit", exit_a, 32'hCD);
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0; req.r_ready = 1'b0;

    // Reset while a B response is pending: it must vanish.
    req.aw_addr = A_REG2; req.w_data = 32'hFFFF; req.w_strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    check("mid_bvalid", resp.b_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", resp.b_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req.b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req.b_ready = 1'b0;
    check("mid_rst_reg_q", reg_q_a, RST_VAL);
    check("mid_rst_exit", exit_a, 32'h0000_0020);

    repeat (2) @(posedge clk);
    #1;
    check("queues_drained", bq.size() + rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_regfile.md
# ctrl_regfile

Parametrised AXI-Lite control/status register file for the Ara SoC: the generalised successor of the fixed three-register SoC control block. Exposes `NumRegs` software-visible registers with per-register read-only/read-write mode, hardware load ports, per-register write pulses, a sticky exit flag, and a free-running 64-bit cycle counter with atomic hi/lo snapshot. Sits on the SoC AXI-Lite peripheral bus next to the DRAM and boot peripherals.

## Interface
- `DataWidth`, 32: register and AXI-Lite data width; 32 or 64 only.
- `AddrWidth`, 32: AXI-Lite address width.
- `NumRegs`, 3: number of general registers, 1..64.
- `ReadOnlyMask`, '0: `[NumRegs-1:0]`; bit i set makes register i read-only to AXI.
- `RegRstVal`, '0: `[NumRegs-1:0][DataWidth-1:0]` reset values.
- `axi_lite_req_t`, logic: AXI-Lite request struct.
- `axi_lite_resp_t`, logic: AXI-Lite response struct.
- `clk_i` in 1: clock; single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `axi_lite_slave_req_i` in struct: AXI-Lite request.
- `axi_lite_slave_resp_o` out struct: AXI-Lite response.
- `reg_d_i` in `[NumRegs][DataWidth]`: hardware load data.
- `reg_load_i` in `NumRegs`: hardware load enable per register.
- `count_en_i` in 1: cycle counter increment enable.
- `reg_q_o` out `[NumRegs][DataWidth]`: current register values.
- `reg_wr_pulse_o` out `NumRegs`: one-cycle pulse after an accepted AXI write to register i.
- `exit_o` out DataWidth: `{reg_q[0][DataWidth-2:0], exit_valid}`.

## Operation
- Word map: index = `addr[AddrWidth-1:log2(DataWidth/8)]`; 0..NumRegs-1 general; next `CntWords = 64/DataWidth` words counter (low word first); any higher index → SLVERR, read data '0, no state change.
- Write: AW and W accepted together in one cycle only when both valid and no B pending (`aw_ready = w_ready = aw_valid & w_valid & ~b_pending`). Byte-strobed update of RW registers. Writes to RO registers or counter words: data dropped, response OKAY, no pulse.
- B held (bvalid) until bready; no new write accepted while held.
- Read: AR accepted when no R pending; data registered; R held until rready.
- Hardware load: `reg_load_i[i]` overwrites register i next cycle regardless of RO mode; on same-cycle collision with AXI write to i, hardware load wins entirely, write still gets OKAY and pulse.
- Exit: `exit_valid` set on first accepted AXI write to register 0 (any strobe), sticky until reset.
- Counter: 64-bit, +1 per cycle with `count_en_i`, wraps 2^64-1 → 0. DataWidth=32: reading low word latches high word into snapshot; high-word reads return snapshot (reset 0). DataWidth=64: single word, no snapshot.
- Simultaneous read and write to same register: read returns pre-write value.

## Timing
- Reset: all registers = RegRstVal, counter 0, snapshot 0, exit_valid 0, all valid/ready outputs 0, `reg_wr_pulse_o` 0.
- Write handshake at cycle t → `reg_q_o` updated, `reg_wr_pulse_o[i]` high, bvalid high, all at t+1; earliest next write acceptance t+2 if bready at t+1.
- Read handshake at t → rvalid and data at t+1; read data samples register state at t.
- Counter value read = value at AR handshake cycle.
- Reset mid-transaction: pending B/R discarded; no response issued after reset.

## Structure
- Package `ctrl_regfile_pkg`: AXI resp codes (OKAY 2'b00, SLVERR 2'b10), `CntWords` function, index-width helper, address-decode result enum (GENERAL, COUNTER, INVALID).
- Sub-module `ctrl_regfile_counter`: 64-bit counter plus hi snapshot, inputs increment enable and lo-read strobe.
- Write/read channel FSMs (IDLE, RESP) and decode in top module.

## Test plan
- Reset → `reg_q_o` = RegRstVal, exit_o = {RegRstVal[0][DataWidth-2:0],0}, counter read 0 after reset-release with `count_en_i` low.
- Write 0x5 to reg 0 strb all-ones, bready delayed 3 cycles → reg_q[0]=0x5 at t+1, pulse[0] one cycle, bvalid held 3 cycles, exit_o = 0xB (DataWidth 32).
- Write 0xFFFF_FFFF to RO reg 1 → OKAY, value unchanged, no pulse; strb 4'b0010 write 0xAABBCCDD to RW reg → only byte 1 becomes 0xCC.
- Read index NumRegs+2 (DataWidth 32) → SLVERR, rdata 0; write there → SLVERR, no state change.
- Preload counter to 0x0000_0000_FFFF_FFFF, enable; read lo → 0xFFFF_FFFF, read hi 10 cycles later → 0 (snapshot, not 1).
- Same cycle `reg_load_i[2]` with 0x1234 and AXI write 0x9 to reg 2 → reg_q[2]=0x1234, OKAY, pulse[2] asserted.
